row_fetch_arbiter: RTL and testbench

ROW_FETCH_ARBITER -- requirements
Module: row_fetch_arbiter

---
 rtl/row_fetch_arbiter.sv | 141 ++++++++++++++
 tb/tb_row_fetch_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/row_fetch_arbiter.sv
// Round-robin row-fetch arbiter: serves X/Y search channels from one row memory.
// Optional FETCH_WATCHDOG_EN aborts a WAIT that exceeds WD_LIMIT cycles and pulses FetchError.
module row_fetch_arbiter #(
    parameter int ADDR_W   = 6,
    parameter int ROWS     = 64,
    parameter int WD_LIMIT = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ReqX,
    input  logic              ReqY,
    input  logic              ClearRows,
    input  logic              MemAck,
    output logic              MemRd,
    output logic [ADDR_W-1:0] MemAddr,
    output logic              RowValidX,
    output logic              RowValidY,
    output logic              RowWrapX,
    output logic              RowWrapY,
    output logic              Busy,
    output logic              FetchError
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);

    if (ROWS < 2 || ROWS > (1 << ADDR_W)) begin : g_bad_rows
        $error("ROWS must lie in 2..2**ADDR_W");
    end
    if (WD_LIMIT < 1) begin : g_bad_wd
        $error("WD_LIMIT must be at least 1");
    end

    logic [1:0]        r_state;
    logic              r_owner;     // 0 = X, 1 = Y
    logic              r_last;      // channel served most recently
    logic [ADDR_W-1:0] r_cnt_x;
    logic [ADDR_W-1:0] r_cnt_y;
    logic [ADDR_W-1:0] r_addr;

    logic              w_grant_y;
    logic [ADDR_W-1:0] w_owner_cnt;
    logic              w_done;
    logic              w_wrap;
    logic [ADDR_W-1:0] w_owner_next;

    // With both requesting, the channel not served last wins.
    assign w_grant_y    = (ReqX && ReqY) ? ~r_last : ReqY;
    assign w_owner_cnt  = r_owner ? r_cnt_y : r_cnt_x;
    assign w_done       = (r_state == DONE);
    assign w_wrap       = w_done && !ClearRows && (w_owner_cnt == LAST_ROW);
    assign w_owner_next = (w_owner_cnt == LAST_ROW) ? '0 : w_owner_cnt + 1'b1;

`ifdef FETCH_WATCHDOG_EN
    localparam int            WD_W    = (WD_LIMIT > 1) ? $clog2(WD_LIMIT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_LIMIT - 1);

    logic [WD_W-1:0] r_wd_cnt;
    logic            r_fetch_err;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
            r_cnt_x <= '0;
            r_cnt_y <= '0;
            r_addr  <= '0;
`ifdef FETCH_WATCHDOG_EN
            r_wd_cnt    <= '0;
            r_fetch_err <= 1'b0;
`endif
        end else begin
`ifdef FETCH_WATCHDOG_EN
            r_fetch_err <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (ReqX || ReqY) begin
                        r_owner <= w_grant_y;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_addr  <= w_owner_cnt;
                    r_state <= WAIT;
`ifdef FETCH_WATCHDOG_EN
                    r_wd_cnt <= '0;
`endif
                end
                WAIT: begin
                    if (MemAck) begin
                        r_state <= DONE;
`ifdef FETCH_WATCHDOG_EN
                    end else if (r_wd_cnt == WD_LAST) begin
                        r_fetch_err <= 1'b1;
                        r_last      <= r_owner;
                        r_state     <= IDLE;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 1'b1;
`endif
                    end
                end
                DONE: begin
                    if (r_owner) r_cnt_y <= w_owner_next;
                    else         r_cnt_x <= w_owner_next;
                    r_last  <= r_owner;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
            // NOTE: the later non-blocking assignment wins, so a matrix change
            // overrides the DONE increment without extra priority logic.
            if (ClearRows) begin
                r_cnt_x <= '0;
                r_cnt_y <= '0;
            end
        end
    end

    assign Busy      = (r_state != IDLE);
    assign MemRd     = (r_state == ISSUE);
    assign MemAddr   = (r_state == IDLE)  ? '0 :
                       (r_state == ISSUE) ? w_owner_cnt : r_addr;
    assign RowValidX = w_done && !r_owner;
    assign RowValidY = w_done &&  r_owner;
    assign RowWrapX  = w_wrap && !r_owner;
    assign RowWrapY  = w_wrap &&  r_owner;

`ifdef FETCH_WATCHDOG_EN
    assign FetchError = r_fetch_err;
`else
    assign FetchError = 1'b0;
`endif

endmodule

// File: tb/tb_row_fetch_arbiter.sv
// Scoreboard bench for row_fetch_arbiter: expected reads/completions are queued by the
// stimulus and consumed by a monitor. Define FETCH_WATCHDOG_EN to exercise the watchdog.
module tb_row_fetch_arbiter;

    localparam int ADDR_W   = 6;
    localparam int ROWS     = 64;
    localparam int WD_LIMIT = 16;

    typedef struct packed {
        logic vx;
        logic vy;
        logic wx;
        logic wy;
        logic err;
    } done_t;

    logic              clock = 1'b0;
    logic              reset;
    logic              ReqX, ReqY, ClearRows, MemAck;
    logic              MemRd;
    logic [ADDR_W-1:0] MemAddr;
    logic              RowValidX, RowValidY, RowWrapX, RowWrapY, Busy, FetchError;

    int n_checks = 0;
    int n_errors = 0;

    logic [ADDR_W-1:0] rd_q[$];
    done_t             done_q[$];

    row_fetch_arbiter #(.ADDR_W(ADDR_W), .ROWS(ROWS), .WD_LIMIT(WD_LIMIT)) dut (
        .clock     (clock),
        .reset     (reset),
        .ReqX      (ReqX),
        .ReqY      (ReqY),
        .ClearRows (ClearRows),
        .MemAck    (MemAck),
        .MemRd     (MemRd),
        .MemAddr   (MemAddr),
        .RowValidX (RowValidX),
        .RowValidY (RowValidY),
        .RowWrapX  (RowWrapX),
        .RowWrapY  (RowWrapY),
        .Busy      (Busy),
        .FetchError(FetchError)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every read strobe and every completion against the queues.
    always @(negedge clock) begin
        if (!reset) begin
            if (MemRd) begin
                if (rd_q.size() == 0) check("unexpected_memrd", 1, 0);
                else check("memrd_addr", int'(MemAddr), int'(rd_q.pop_front()));
            end
            if (RowValidX || RowValidY || FetchError) begin
                if (done_q.size() == 0) check("unexpected_done", 1, 0);
                else check("done_flags",
                           int'({RowValidX, RowValidY, RowWrapX, RowWrapY, FetchError}),
                           int'(done_q.pop_front()));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic expect_fetch(input int addr, input bit y, input bit wrap, input bit err);
        done_t d;
        rd_q.push_back(ADDR_W'(addr));
        d.vx  = !y && !err;
        d.vy  =  y && !err;
        d.wx  = !y && wrap;
        d.wy  =  y && wrap;
        d.err = err;
        done_q.push_back(d);
    endtask

    // Waits for the read strobe (bounded), acks after ack_delay WAIT cycles, runs DONE.
    task automatic serve(input int ack_delay, input bit clear_at_done, input bit drop_req);
        int waited = 0;
        do begin
            @(negedge clock);
            waited++;
        end while (!MemRd && waited < 20);
        if (!MemRd) begin
            check("memrd_timeout", 0, 1);
            return;
        end
        check("grant_latency", waited, 2);
        step(1);
        if (drop_req) begin
            ReqX = 1'b0;
            ReqY = 1'b0;
        end
        step(ack_delay);
        MemAck = 1'b1;
        step(1);
        MemAck    = 1'b0;
        ClearRows = clear_at_done;
        step(1);
        ClearRows = 1'b0;
    endtask

    task automatic fetch(input bit y, input int addr, input bit wrap, input int ack_delay,
                         input bit clear_at_done);
        expect_fetch(addr, y, wrap, 1'b0);
        ReqX = !y;
        ReqY = y;
        serve(ack_delay, clear_at_done, 1'b1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ReqX = 1'b0; ReqY = 1'b0; ClearRows = 1'b0; MemAck = 1'b0;
        step(2);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        ReqX = 1'b0; ReqY = 1'b0; ClearRows = 1'b0; MemAck = 1'b1;
        step(3);
        check("reset_busy",   int'(Busy), 0);
        check("reset_memrd",  int'(MemRd), 0);
        check("reset_addr",   int'(MemAddr), 0);
        check("reset_valid",  int'({RowValidX, RowValidY, RowWrapX, RowWrapY}), 0);
        check("reset_error",  int'(FetchError), 0);
        MemAck = 1'b0;
        reset  = 1'b0;

        // Single X fetches: address 0 then 1.
        fetch(1'b0, 0, 1'b0, 0, 1'b0);
        fetch(1'b0, 1, 1'b0, 0, 1'b0);

        // Both requesting: X,Y,X,Y with addresses 0,0,1,1, back-to-back.
        do_reset();
        expect_fetch(0, 1'b0, 1'b0, 1'b0);
        expect_fetch(0, 1'b1, 1'b0, 1'b0);
        expect_fetch(1, 1'b0, 1'b0, 1'b0);
        expect_fetch(1, 1'b1, 1'b0, 1'b0);
        ReqX = 1'b1;
        ReqY = 1'b1;
        for (int i = 0; i < 4; i++) serve(0, 1'b0, i == 3);

        // Full sweep of X: wrap on the 64th fetch, then address 0 again.
        do_reset();
        for (int i = 0; i < ROWS; i++) fetch(1'b0, i, i == ROWS - 1, 0, 1'b0);
        fetch(1'b0, 0, 1'b0, 1, 1'b0);

        // Matrix change coincident with DONE at counter 5.
        do_reset();
        for (int i = 0; i < 5; i++) fetch(1'b0, i, 1'b0, 0, 1'b0);
        fetch(1'b0, 5, 1'b0, 0, 1'b1);
        fetch(1'b0, 0, 1'b0, 2, 1'b0);

`ifdef FETCH_WATCHDOG_EN
        // Ack withheld: error after WD_LIMIT WAIT cycles, then Y is granted.
        do_reset();
        fetch(1'b0, 0, 1'b0, 0, 1'b0);
        expect_fetch(1, 1'b0, 1'b0, 1'b1);
        ReqX = 1'b1;
        begin : wd_wait
            int waited = 0;
            do begin
                @(negedge clock);
                waited++;
            end while (!MemRd && waited < 20);
            check("wd_memrd_seen", int'(MemRd), 1);
        end
        step(1);
        ReqX = 1'b0;
        ReqY = 1'b1;
        step(WD_LIMIT - 1);
        check("wd_last_wait_busy", int'(Busy), 1);
        check("wd_last_wait_err",  int'(FetchError), 0);
        step(1);
        check("wd_err_pulse", int'(FetchError), 1);
        check("wd_err_idle",  int'(Busy), 0);
        expect_fetch(0, 1'b1, 1'b0, 1'b0);
        serve(0, 1'b0, 1'b1);
        check("wd_err_cleared", int'(FetchError), 0);
        fetch(1'b0, 1, 1'b0, 0, 1'b0);
`else
        // Without the watchdog a long WAIT simply completes.
        do_reset();
        fetch(1'b0, 0, 1'b0, WD_LIMIT + 4, 1'b0);
        fetch(1'b0, 1, 1'b0, 0, 1'b0);
`endif

        // Reset while waiting for the ack; the late ack must be ignored.
        do_reset();
        fetch(1'b0, 0, 1'b0, 0, 1'b0);
        rd_q.push_back(ADDR_W'(1));
        ReqX = 1'b1;
        begin : rst_wait
            int waited = 0;
            do begin
                @(negedge clock);
                waited++;
            end while (!MemRd && waited < 20);
            check("rst_memrd_seen", int'(MemRd), 1);
        end
        step(1);
        ReqX = 1'b0;
        step(2);
        check("rst_in_wait_busy", int'(Busy), 1);
        reset = 1'b1;
        step(1);
        reset  = 1'b0;
        MemAck = 1'b1;
        step(1);
        MemAck = 1'b0;
        step(3);
        check("rst_abandon_busy", int'(Busy), 0);
        fetch(1'b0, 0, 1'b0, 0, 1'b0);
        fetch(1'b1, 0, 1'b0, 0, 1'b0);

        step(2);
        check("rd_q_drained",   rd_q.size(), 0);
        check("done_q_drained", done_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
